k2_sequencer: RTL and testbench

- Multi-cycle control FSM for the 8-bit K2 datapath (4-bit PC, 16-entry instruction ROM, RA/RB/RO registers, add/sub ALU, carry flop).
- Replaces the single-cycle decode with a FETCH/EXEC/UPDATE sequence.
- Adds run/step/stop control, a PC breakpoint and a retired-instruction counter.
- Drives all datapath enables and mux selects; the datapath stays unchanged apart from taking these controls.

---
 rtl/k2_sequencer.sv | 103 ++++++++++
 tb/tb_k2_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/k2_sequencer.sv
// k2_sequencer: FETCH/EXEC/UPDATE control FSM for the K2 datapath with run/step/stop, breakpoint and retire counter
module k2_sequencer #(
  parameter int PC_BITS = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                stop,
  input  logic [7:0]          instr_in,
  input  logic [PC_BITS-1:0]  pc_in,
  input  logic                carry_flag,
  input  logic                bp_en,
  input  logic [PC_BITS-1:0]  bp_addr,
  output logic                pc_inc,
  output logic                pc_load,
  output logic [PC_BITS-1:0]  pc_target,
  output logic                ra_en,
  output logic                rb_en,
  output logic                ro_en,
  output logic                imm_sel,
  output logic                ra_zero,
  output logic                rb_sel,
  output logic                alu_sub,
  output logic                carry_en,
  output logic                busy,
  output logic                bp_hit,
  output logic [CNT_BITS-1:0] instr_count
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, UPDATE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic single_q, single_d, stop_pend_q, stop_pend_d, bp_hit_q, bp_hit_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic exec, upd, take, halt;
  logic [PC_BITS-1:0] next_pc;
  assign exec = state_q == EXEC;
  assign upd = state_q == UPDATE;
  assign take = ir_q[7] | (ir_q[6] & carry_flag);
  assign halt = stop_pend_q | stop | single_q;
  assign next_pc = take ? pc_target : pc_in + PC_BITS'(1);
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    single_d = single_q;
    stop_pend_d = stop_pend_q;
    cnt_d = cnt_q;
    bp_hit_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = (run | step) ? FETCH : IDLE;
        single_d = (run | step) ? ~run : single_q;
      end
      FETCH: begin
        ir_d = instr_in;
        state_d = EXEC;
        stop_pend_d = stop_pend_q | stop;
      end
      EXEC: begin
        state_d = UPDATE;
        stop_pend_d = stop_pend_q | stop;
      end
      default: begin
        cnt_d = cnt_q + CNT_BITS'(1);
        bp_hit_d = ~halt & bp_en & (next_pc == bp_addr);
        state_d = (halt | bp_hit_d) ? IDLE : FETCH;
        stop_pend_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q <= 8'h00;
      single_q <= 1'b0;
      stop_pend_q <= 1'b0;
      bp_hit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      single_q <= single_d;
      stop_pend_q <= stop_pend_d;
      bp_hit_q <= bp_hit_d;
      cnt_q <= cnt_d;
    end
  end
  assign pc_target = PC_BITS'(ir_q[2:0]);
  assign pc_load = upd & take;
  assign pc_inc = upd & ~take;
  assign ra_en = exec & (ir_q[5:4] == 2'b00);
  assign rb_en = exec & (ir_q[5:4] == 2'b01);
  assign ro_en = exec & (ir_q[5:4] == 2'b10);
  assign imm_sel = exec & ir_q[3];
  assign alu_sub = exec & ir_q[2];
  assign ra_zero = exec & ir_q[1];
  assign rb_sel = exec & ir_q[0];
  assign carry_en = exec & ~ir_q[3] & ~ir_q[5];
  assign busy = state_q != IDLE;
  assign bp_hit = bp_hit_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_k2_sequencer.sv
// tb_k2_sequencer: vector table of directed and model-generated instruction episodes checked cycle by cycle
module tb_k2_sequencer;
  typedef struct {
    logic rst, run, step, stop, carry, bpe, chk;
    logic [3:0] bpa, pc;
    logic [7:0] ins;
    logic [15:0] eo, ec;
  } rec_t;
  logic clk = 0, reset = 1, run = 0, step = 0, stop = 0, carry_flag = 0, bp_en = 0;
  logic [7:0] instr_in = 0;
  logic [3:0] pc_in = 0, bp_addr = 0, pc_target;
  logic pc_inc, pc_load, ra_en, rb_en, ro_en, imm_sel, ra_zero, rb_sel, alu_sub, carry_en, busy, bp_hit;
  logic [15:0] instr_count, act, m, mcnt;
  logic [7:0] rom [16];
  rec_t tbl[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  k2_sequencer #(.PC_BITS(4), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .stop(stop),
    .instr_in(instr_in), .pc_in(pc_in), .carry_flag(carry_flag),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_target(pc_target), .ra_en(ra_en), .rb_en(rb_en), .ro_en(ro_en),
    .imm_sel(imm_sel), .ra_zero(ra_zero), .rb_sel(rb_sel), .alu_sub(alu_sub),
    .carry_en(carry_en), .busy(busy), .bp_hit(bp_hit), .instr_count(instr_count)
  );
  // bit order: pc_inc pc_load target[3:0] ra rb ro imm ra_zero rb_sel sub carry_en busy bp_hit
  function automatic logic [15:0] ev(int ph, logic [7:0] i, logic c, logic h);
    logic [15:0] v;
    v = 16'd0;
    if (ph == 0) return {15'd0, h};
    v[1] = 1'b1;
    if (ph == 2) begin
      if (i[5:4] != 2'd3) v[9 - i[5:4]] = 1'b1;
      v[6] = i[3];
      v[5] = i[1];
      v[4] = i[0];
      v[3] = i[2];
      v[2] = !i[3] && i[5:4] < 2'd2;
    end
    if (ph == 3) begin
      if (i[7] || (i[6] && c)) begin
        v[14] = 1'b1;
        v[13:10] = {1'b0, i[2:0]};
      end else v[15] = 1'b1;
    end
    return v;
  endfunction
  function automatic rec_t mk(logic chk, logic rst, logic rn, logic st, logic sp, logic c,
                              logic [7:0] ins, logic [15:0] eo, logic [15:0] ec);
    rec_t r;
    r.chk = chk; r.rst = rst; r.run = rn; r.step = st; r.stop = sp; r.carry = c;
    r.ins = ins; r.eo = eo; r.ec = ec; r.bpe = 0; r.bpa = 0; r.pc = 0;
    return r;
  endfunction
  task automatic episode(input bit is_run, input bit both, input bit be, input logic [3:0] ba,
                         input logic [3:0] pc0, input int stop_at);
    rec_t r;
    logic [3:0] pc, np;
    logic [7:0] ins;
    logic c;
    bit stp, hit, done;
    int t;
    pc = pc0; t = 1; stp = 0; hit = 0; done = 0; ins = rom[pc0];
    r = mk(1, 0, is_run, !is_run || both, 0, 0, rom[pc], 16'd0, mcnt);
    r.bpe = be; r.bpa = ba; r.pc = pc;
    tbl.push_back(r);
    while (!done) begin
      ins = rom[pc];
      c = 1'($urandom);
      for (int ph = 1; ph <= 3; ph++) begin
        r = mk(1, 0, 0, 0, t == stop_at, c, ins, ev(ph, ins, c, 0), mcnt);
        r.bpe = be; r.bpa = ba; r.pc = pc;
        tbl.push_back(r);
        stp = stp || (t == stop_at);
        t++;
      end
      np = (ins[7] || (ins[6] && c)) ? {1'b0, ins[2:0]} : pc + 4'd1;
      mcnt++;
      hit = !stp && is_run && be && np == ba;
      done = stp || !is_run || hit;
      pc = np;
    end
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, ins, {15'd0, hit}, mcnt));
  endtask
  initial begin
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'h0B, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h0B, 16'h0002, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h0B, 16'h0272, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h0B, 16'h8002, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'hB5, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'hB5, 16'h0002, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'hB5, 16'h001A, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'hB5, 16'h5402, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'h72, 16'h0000, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h72, 16'h0002, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h72, 16'h0022, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h72, 16'h8002, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 8'h72, 16'h0000, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h72, 16'h0002, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h72, 16'h0022, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h72, 16'h4802, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 4));
    mcnt = 4;
    foreach (rom[i]) rom[i] = 8'h00;
    episode(1, 0, 0, 0, 4'($urandom), 5);
    foreach (rom[i]) rom[i] = 8'h0B;
    episode(1, 0, 1, 4'd3, 4'd2, 0);
    episode(1, 0, 1, 4'd0, 4'd15, 0);
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 8'h00, 16'h0000, mcnt));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0002, mcnt));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, ev(2, 8'h00, 0, 0), mcnt));
    mcnt = 0;
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0));
    foreach (rom[i]) rom[i] = 8'($urandom) & 8'h3F;
    episode(1, 1, 0, 0, 4'($urandom), 4);
    for (int e = 0; e < 40; e++) begin
      bit r_run;
      foreach (rom[i]) rom[i] = 8'($urandom);
      r_run = 1'($urandom);
      episode(r_run, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              r_run ? int'($urandom_range(1, 30)) : int'($urandom_range(0, 4)));
    end
    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; run = tbl[i].run; step = tbl[i].step; stop = tbl[i].stop;
      carry_flag = tbl[i].carry; bp_en = tbl[i].bpe; bp_addr = tbl[i].bpa;
      pc_in = tbl[i].pc; instr_in = tbl[i].ins;
      #1;
      if (tbl[i].chk) begin
        checks++;
        act = {pc_inc, pc_load, pc_target, ra_en, rb_en, ro_en, imm_sel, ra_zero, rb_sel,
               alu_sub, carry_en, busy, bp_hit};
        m = tbl[i].eo[14] ? 16'hFFFF : 16'hC3FF;
        if ((act & m) !== tbl[i].eo || instr_count !== tbl[i].ec) begin
          errors++;
          $display("FAIL rec %0d: outputs=%h count=%0d, expected outputs=%h count=%0d",
                   i, act & m, instr_count, tbl[i].eo, tbl[i].ec);
        end
      end
    end
    @(negedge clk);
    reset = 1; run = 0; step = 0; stop = 0; instr_in = 8'hFF;
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    act = {pc_inc, pc_load, pc_target, ra_en, rb_en, ro_en, imm_sel, ra_zero, rb_sel,
           alu_sub, carry_en, busy, bp_hit};
    if (act !== 16'd0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset state: outputs=%h count=%0d", act, instr_count);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    act = {pc_inc, pc_load, pc_target, ra_en, rb_en, ro_en, imm_sel, ra_zero, rb_sel,
           alu_sub, carry_en, busy, bp_hit};
    if (act !== 16'd0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL idle wait: outputs=%h count=%0d", act, instr_count);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
